// File: rtl/way_miss_controller.sv
// Miss/hit sequencer for a fully-associative cache: lookup, victim choice,
// optional writeback, line fill and allocation, then a one-cycle response.
module way_miss_controller #(
  parameter int NUM_WAYS         = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int BLOCK_SIZE       = 32,
  parameter int ADDRESS_WIDTH    = 32,
  localparam int WORDS_PER_BLOCK = BLOCK_SIZE / (DATA_WIDTH / 8),
  localparam int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK),
  localparam int TAG_WIDTH       = ADDRESS_WIDTH - OFFSET_WIDTH,
  localparam int LINE_WIDTH      = DATA_WIDTH * WORDS_PER_BLOCK
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [ADDRESS_WIDTH-1:0]       req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  input  logic [NUM_WAYS-1:0]            way_valid,
  input  logic [NUM_WAYS-1:0]            way_dirty,
  input  logic [NUM_WAYS-1:0]            way_expired,
  input  logic [NUM_WAYS-1:0]            way_hit,
  input  logic [NUM_WAYS*TAG_WIDTH-1:0]  way_tag,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0] way_rdata,
  input  logic [NUM_WAYS*LINE_WIDTH-1:0] way_line,
  output logic [ADDRESS_WIDTH-1:0]       way_line_address,
  output logic [OFFSET_WIDTH-1:0]        way_offset,
  output logic [DATA_WIDTH-1:0]          way_wdata,
  output logic [NUM_WAYS-1:0]            way_wen,
  output logic [NUM_WAYS-1:0]            way_allocate,
  output logic [LINE_WIDTH-1:0]          way_fetched_line,
  output logic [NUM_WAYS-1:0]            way_accessed,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic                           mem_req_we,
  output logic [ADDRESS_WIDTH-1:0]       mem_req_addr,
  output logic [LINE_WIDTH-1:0]          mem_wline,
  input  logic                           mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]          mem_rline,
  output logic [31:0]                    hit_count,
  output logic [31:0]                    miss_count
);
  localparam int WAY_IDX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [NUM_WAYS-1:0] WAY_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, ALLOCATE, RESPOND
  } state_t;

  state_t                     state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0]   addr_reg;
  logic                       we_reg;
  logic [DATA_WIDTH-1:0]      wdata_reg;
  logic [DATA_WIDTH-1:0]      rdata_reg;
  logic                       hit_reg;
  logic [WAY_IDX_WIDTH-1:0]   victim_reg;
  logic [ADDRESS_WIDTH-1:0]   wb_addr_reg;
  logic [LINE_WIDTH-1:0]      wb_line_reg;
  logic [LINE_WIDTH-1:0]      fill_line_reg;
  logic [31:0]                hit_count_reg, miss_count_reg;

  logic [TAG_WIDTH-1:0]       tag_arr   [NUM_WAYS];
  logic [DATA_WIDTH-1:0]      rdata_arr [NUM_WAYS];
  logic [LINE_WIDTH-1:0]      line_arr  [NUM_WAYS];

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_unpack
      assign tag_arr[gi]   = way_tag[gi*TAG_WIDTH +: TAG_WIDTH];
      assign rdata_arr[gi] = way_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign line_arr[gi]  = way_line[gi*LINE_WIDTH +: LINE_WIDTH];
    end
  endgenerate

  logic                     hit_any, inv_found, exp_found;
  logic [WAY_IDX_WIDTH-1:0] hit_idx, inv_idx, exp_idx, victim_idx;
  logic [LINE_WIDTH-1:0]    merged_line;

  assign hit_any = |way_hit;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_idx    = '0;
    inv_idx    = '0;
    exp_idx    = '0;
    inv_found  = 1'b0;
    exp_found  = 1'b0;
    victim_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) hit_idx = WAY_IDX_WIDTH'(i);
      if (!way_valid[i]) begin
        inv_idx   = WAY_IDX_WIDTH'(i);
        inv_found = 1'b1;
      end
      if (way_expired[i]) begin
        exp_idx   = WAY_IDX_WIDTH'(i);
        exp_found = 1'b1;
      end
    end
    victim_idx = inv_found ? inv_idx : (exp_found ? exp_idx : '0);
  end

  assign way_line_address = addr_reg;
  assign way_offset       = addr_reg[OFFSET_WIDTH-1:0];
  assign way_wdata        = wdata_reg;
  assign hit_count        = hit_count_reg;
  assign miss_count       = miss_count_reg;

  always_comb begin
    merged_line = fill_line_reg;
    if (we_reg) merged_line[way_offset*DATA_WIDTH +: DATA_WIDTH] = wdata_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (req_valid) state_next = LOOKUP;
      LOOKUP: begin
        if (hit_any)                                             state_next = RESPOND;
        else if (way_valid[victim_idx] && way_dirty[victim_idx]) state_next = WB_REQ;
        else                                                     state_next = FILL_REQ;
      end
      WB_REQ:    if (mem_req_ready) state_next = FILL_REQ;
      FILL_REQ:  if (mem_req_ready) state_next = FILL_WAIT;
      FILL_WAIT: if (mem_resp_valid) state_next = ALLOCATE;
      ALLOCATE:  state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = (state_reg == IDLE);
    resp_valid       = (state_reg == RESPOND);
    resp_hit         = resp_valid & hit_reg;
    resp_rdata       = resp_valid ? rdata_reg : '0;
    way_wen          = '0;
    way_allocate     = '0;
    way_accessed     = '0;
    way_fetched_line = '0;
    mem_req_valid    = 1'b0;
    mem_req_we       = 1'b0;
    mem_req_addr     = '0;
    mem_wline        = '0;
    case (state_reg)
      LOOKUP: begin
        if (hit_any) begin
          way_accessed = WAY_ONE << hit_idx;
          if (we_reg) way_wen = WAY_ONE << hit_idx;
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = wb_addr_reg;
        mem_wline     = wb_line_reg;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_reg[ADDRESS_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
      end
      ALLOCATE: begin
        way_allocate     = WAY_ONE << victim_reg;
        way_accessed     = WAY_ONE << victim_reg;
        way_fetched_line = merged_line;
      end
      default: ;
    endcase
  end

  // Victim tag and line are snapshotted at lookup so the writeback request
  // stays stable however long memory stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      hit_reg        <= 1'b0;
      victim_reg     <= '0;
      wb_addr_reg    <= '0;
      wb_line_reg    <= '0;
      fill_line_reg  <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg  <= req_addr;
            we_reg    <= req_we;
            wdata_reg <= req_wdata;
          end
        end
        LOOKUP: begin
          if (hit_any) begin
            hit_reg       <= 1'b1;
            rdata_reg     <= we_reg ? '0 : rdata_arr[hit_idx];
            hit_count_reg <= hit_count_reg + 32'd1;
          end else begin
            hit_reg        <= 1'b0;
            victim_reg     <= victim_idx;
            wb_addr_reg    <= {tag_arr[victim_idx], {OFFSET_WIDTH{1'b0}}};
            wb_line_reg    <= line_arr[victim_idx];
            miss_count_reg <= miss_count_reg + 32'd1;
          end
        end
        FILL_WAIT: if (mem_resp_valid) fill_line_reg <= mem_rline;
        ALLOCATE:  rdata_reg <= we_reg ? '0 : fill_line_reg[way_offset*DATA_WIDTH +: DATA_WIDTH];
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_way_miss_controller.sv
// Bench for way_miss_controller: the bench plays the way array and memory,
// and checks responses against a flat word-addressed golden memory.
module tb_way_miss_controller;
  localparam int NW = 4, DW = 32, OW = 3, TW = 29, LW = 256, AW = 32;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic resp_valid, resp_hit;
  logic [DW-1:0] resp_rdata;
  logic [NW-1:0] way_valid, way_dirty, way_expired, way_hit;
  logic [NW*TW-1:0] way_tag;
  logic [NW*DW-1:0] way_rdata;
  logic [NW*LW-1:0] way_line;
  logic [AW-1:0] way_line_address;
  logic [OW-1:0] way_offset;
  logic [DW-1:0] way_wdata;
  logic [NW-1:0] way_wen, way_allocate, way_accessed;
  logic [LW-1:0] way_fetched_line;
  logic mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_wline;
  logic mem_resp_valid;
  logic [LW-1:0] mem_rline;
  logic [31:0] hit_count, miss_count;

  way_miss_controller dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .way_valid(way_valid), .way_dirty(way_dirty), .way_expired(way_expired),
    .way_hit(way_hit), .way_tag(way_tag), .way_rdata(way_rdata), .way_line(way_line),
    .way_line_address(way_line_address), .way_offset(way_offset), .way_wdata(way_wdata),
    .way_wen(way_wen), .way_allocate(way_allocate), .way_fetched_line(way_fetched_line),
    .way_accessed(way_accessed),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_wline(mem_wline),
    .mem_resp_valid(mem_resp_valid), .mem_rline(mem_rline),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Way array contents owned by the bench.
  logic [TW-1:0] w_tag  [NW];
  logic [LW-1:0] w_line [NW];
  logic [NW-1:0] w_valid, w_dirty, w_expired;
  logic [LW-1:0] mem_model [256];
  logic [DW-1:0] gold [2048];
  int n_vec = 0, n_err = 0;
  int exp_hits = 0, exp_misses = 0;

  always_comb begin
    way_valid   = w_valid;
    way_dirty   = w_dirty;
    way_expired = w_expired;
    way_hit     = '0;
    way_tag     = '0;
    way_rdata   = '0;
    way_line    = '0;
    for (int i = 0; i < NW; i++) begin
      way_hit[i]              = w_valid[i] && (w_tag[i] == way_line_address[AW-1:OW]);
      way_tag[i*TW +: TW]     = w_tag[i];
      way_line[i*LW +: LW]    = w_line[i];
      way_rdata[i*DW +: DW]   = w_line[i][way_offset*DW +: DW];
    end
  end

  function automatic logic [31:0] init_word(input int a);
    return 32'hAAAA0000 + 32'(a) - 32'h100;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke_way(input int i, input logic [TW-1:0] t, input bit d);
    w_valid[i] = 1'b1;
    w_tag[i]   = t;
    w_dirty[i] = d;
    for (int w = 0; w < 8; w++) w_line[i][w*DW +: DW] = gold[11'(int'(t) * 8 + w)];
  endtask

  // One CPU transaction; the bench acts as way array and memory cycle by cycle.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall_wb, input bit abort_fill);
    logic [TW-1:0] tag;
    logic [OW-1:0] off;
    logic [31:0]   exp_rdata;
    logic [LW-1:0] exp_line;
    bit exp_hit, exp_wb, wb_seen, fill_seen, fill_pending, done, aborted;
    bit pend_hit_upd, pend_alloc;
    int h, v, n, delay, stall_left;
    tag = addr[AW-1:OW];
    off = addr[OW-1:0];
    exp_hit = 0; h = 0;
    for (int i = NW - 1; i >= 0; i--)
      if (w_valid[i] && w_tag[i] == tag) begin exp_hit = 1; h = i; end
    v = -1;
    for (int i = 0; i < NW; i++) if (v < 0 && !w_valid[i]) v = i;
    for (int i = 0; i < NW; i++) if (v < 0 && w_expired[i]) v = i;
    if (v < 0) v = 0;
    exp_wb    = !exp_hit && w_valid[v] && w_dirty[v];
    exp_rdata = we ? 32'h0 : gold[addr[10:0]];
    exp_line  = '0;
    if (exp_hit) exp_hits++; else exp_misses++;

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0; done = 0; aborted = 0; wb_seen = 0; fill_seen = 0; fill_pending = 0;
    delay = 0; stall_left = stall_wb;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; pend_hit_upd = 0; pend_alloc = 0;
      if (n == 1) begin
        check("line_address", way_line_address, addr);
        check("lookup_accessed", way_accessed, exp_hit ? (4'b1 << h) : 4'b0);
        check("lookup_wen", way_wen, (exp_hit && we) ? (4'b1 << h) : 4'b0);
        pend_hit_upd = exp_hit && we;
      end
      if (mem_req_valid && mem_req_we) begin
        if (!wb_seen) check("wb_expected", exp_wb, 1);
        check("wb_addr", mem_req_addr, {w_tag[v], 3'b000});
        check("wb_line", mem_wline, w_line[v]);
        wb_seen = 1;
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 2) begin mem_resp_valid = 1'b1; mem_rline = {8{32'hBADBAD00}}; end
        end else begin
          mem_req_ready = 1'($urandom_range(0, 1));
          if (mem_req_ready) mem_model[mem_req_addr[10:3]] = mem_wline;
        end
      end else if (mem_req_valid) begin
        if (!fill_seen) check("wb_before_fill", wb_seen, exp_wb);
        check("fill_addr", mem_req_addr, {tag, 3'b000});
        fill_seen = 1;
        mem_req_ready = 1'($urandom_range(0, 1));
        if (mem_req_ready) begin fill_pending = 1; delay = $urandom_range(0, 3); end
      end else if (fill_pending) begin
        if (abort_fill) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          exp_hits = 0; exp_misses = 0;
          check("abort_req_ready", req_ready, 1);
          check("abort_mem_valid", mem_req_valid, 0);
          check("abort_resp_valid", resp_valid, 0);
          check("abort_miss_count", miss_count, exp_misses);
          @(negedge clk);
          mem_resp_valid = 1'b1; mem_rline = mem_model[tag[7:0]];
          @(negedge clk);
          mem_resp_valid = 1'b0;
          check("late_resp_alloc", way_allocate, 0);
          check("late_resp_valid", resp_valid, 0);
          check("late_req_ready", req_ready, 1);
          aborted = 1;
          break;
        end else if (delay == 0) begin
          mem_resp_valid = 1'b1; mem_rline = mem_model[tag[7:0]]; fill_pending = 0;
        end else delay--;
      end
      if (way_allocate != 0) begin
        exp_line = mem_model[tag[7:0]];
        if (we) exp_line[off*DW +: DW] = wdata;
        check("alloc_onehot", way_allocate, 4'b1 << v);
        check("alloc_accessed", way_accessed, 4'b1 << v);
        check("alloc_wen", way_wen, 0);
        check("fetched_line", way_fetched_line, exp_line);
        pend_alloc = 1;
      end
      if (resp_valid) begin
        check("resp_hit", resp_hit, exp_hit);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
        check("fill_seen", fill_seen, !exp_hit);
        check("wb_seen", wb_seen, exp_wb);
        if (exp_hit) check("hit_latency", n, 2);
        done = 1;
      end
      @(posedge clk); #1;
      if (pend_hit_upd) begin w_line[h][off*DW +: DW] = wdata; w_dirty[h] = 1'b1; end
      if (pend_alloc) begin
        w_valid[v] = 1'b1; w_tag[v] = tag; w_line[v] = exp_line; w_dirty[v] = we;
      end
    end
    if (!aborted) begin
      check("resp_timeout", done, 1);
      if (we) gold[addr[10:0]] = wdata;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rline = '0;
    w_valid = '0; w_dirty = '0; w_expired = '0;
    for (int i = 0; i < NW; i++) begin w_tag[i] = '0; w_line[i] = '0; end
    for (int a = 0; a < 2048; a++) gold[a] = init_word(a);
    for (int t = 0; t < 256; t++)
      for (int w = 0; w < 8; w++) mem_model[t][w*DW +: DW] = init_word(t * 8 + w);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_allocate", way_allocate, 0);
    rst = 1'b0;

    // Cold read miss into way 0.
    run_txn(1'b0, 32'h100, 32'h0, 0, 0);
    // Read hit with a distinctive word in way 0.
    w_line[0][3*DW +: DW] = 32'h1234; gold[11'h103] = 32'h1234; w_dirty[0] = 1'b1;
    run_txn(1'b0, 32'h103, 32'h0, 0, 0);
    // Write miss merges write data into the fetched line.
    run_txn(1'b1, 32'h108, 32'hDEADBEEF, 0, 0);
    // Duplicate tag in way 3 with different data: lowest index must win.
    w_valid[3] = 1'b1; w_tag[3] = w_tag[1]; w_dirty[3] = 1'b0;
    w_line[3] = w_line[1] ^ {224'h0, 32'hFFFFFFFF, 32'h0};
    run_txn(1'b0, 32'h109, 32'h0, 0, 0);
    w_valid[3] = 1'b0;
    // All ways valid, way 2 expired and dirty: writeback with a stalled memory.
    for (int w = 0; w < 8; w++) gold[11'(32'h200 + w)] = $urandom;
    poke_way(2, 29'h40, 1'b1);
    poke_way(3, 29'h50, 1'b0);
    w_expired = 4'b0100;
    run_txn(1'b0, 32'h300, 32'h0, 5, 0);
    // Reset while waiting for fill data.
    w_expired = 4'b0000;
    run_txn(1'b0, 32'h118, 32'h0, 0, 1);
    // Randomized traffic over a small address window to force evictions.
    for (int k = 0; k < 150; k++) begin
      w_expired = 4'($urandom);
      run_txn(1'($urandom_range(0, 1)), 32'($urandom_range(32'hC0, 32'h13F)), $urandom, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
